key_scan_arbiter: RTL and testbench

Debounce controller for a bank of mechanical keys that time-shares one debounce timer among all keys instead of instantiating a timer per key. It scans synchronized key levels, grants the shared timer round-robin to one key whose level differs from its debounced state, and confirms the change after T_DEB stable cycles. Each confirmed transition is issued as a press/release event on a valid/ready handshake. It sits between the raw key pins and the mode/LED control logic.

---
 rtl/key_scan_pkg.sv | 14 +
 rtl/key_scan_arbiter_rr_pick.sv | 39 +++
 rtl/key_scan_arbiter.sv | 141 ++++++++++++++
 tb/tb_key_scan_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and defaults for the key scan arbiter and its round-robin picker.
// Default timer terminal count gives 40 ms of stability at a 50 MHz clock.
package key_scan_pkg;

    localparam int DEF_CNT_W = 30;
    localparam logic [DEF_CNT_W-1:0] DEF_T_DEB = 30'd1_999_999;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/key_scan_arbiter_rr_pick.sv
// Combinational round-robin finder: returns the first set request bit at or
// above ptr, wrapping past the top index back to zero.
module rr_pick #(
    parameter int N_KEYS = 4,
    parameter int IDX_W  = $clog2(N_KEYS)
) (
    input  logic [N_KEYS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              any
);

    logic [IDX_W-1:0] cand [N_KEYS];

    // cand[k] is the key index visited k steps after ptr in the circular search
    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(N_KEYS))
                            ? IDX_W'(sum - (IDX_W+1)'(N_KEYS))
                            : IDX_W'(sum);
        end
    endgenerate

    // Scanning from the far end lets the nearest candidate overwrite the rest
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                any     = 1'b1;
                gnt_idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/key_scan_arbiter.sv
// Multi-key debouncer sharing one stability timer: grants the timer round-robin
// to a key whose synchronized level disagrees with its debounced state.
module key_scan_arbiter
    import key_scan_pkg::*;
#(
    parameter int               N_KEYS = 4,
    parameter int               CNT_W  = DEF_CNT_W,
    parameter logic [CNT_W-1:0] T_DEB  = CNT_W'(DEF_T_DEB),
    parameter int               IDX_W  = $clog2(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [IDX_W-1:0]  ev_key,
    output logic              ev_press,
    output logic [N_KEYS-1:0] key_state,
    output logic              busy
);

    state_t            state_q, state_d;
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] key_state_q, key_state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0]  ev_key_q, ev_key_d;
    logic              ev_press_q, ev_press_d;

    logic [N_KEYS-1:0] sync;
    logic [N_KEYS-1:0] mismatch;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  idx_inc;
    logic              abort;

    assign sync     = sync2_q;
    assign mismatch = sync ^ key_state_q;
    assign idx_inc  = (idx_q == IDX_W'(N_KEYS - 1)) ? '0 : idx_q + 1'b1;
    // Granted key drifted back to its debounced level before confirmation
    assign abort    = (sync[idx_q] == key_state_q[idx_q]);

    rr_pick #(
        .N_KEYS (N_KEYS),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .req     (mismatch),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= '1;
            sync2_q     <= '1;
            key_state_q <= '1;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            ev_valid_q  <= 1'b0;
            ev_key_q    <= '0;
            ev_press_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_state_q <= key_state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ev_valid_q  <= ev_valid_d;
            ev_key_q    <= ev_key_d;
            ev_press_q  <= ev_press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = COUNT;
            COUNT: begin
                if (abort)               state_d = IDLE;
                else if (cnt_q == T_DEB) state_d = EMIT;
            end
            EMIT:    if (ev_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sync1_d     = key_in;
        sync2_d     = sync1_q;
        key_state_d = key_state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ev_valid_d  = ev_valid_q;
        ev_key_d    = ev_key_q;
        ev_press_d  = ev_press_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    idx_d = pick_idx;
                    cnt_d = '0;
                end
            end
            COUNT: begin
                if (abort) begin
                    ptr_d = idx_inc;
                end else if (cnt_q == T_DEB) begin
                    // Counter parks at T_DEB so it never wraps
                    key_state_d[idx_q] = sync[idx_q];
                    ev_key_d           = idx_q;
                    ev_press_d         = ~sync[idx_q];
                    ev_valid_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (ev_ready) begin
                    ev_valid_d = 1'b0;
                    ptr_d      = idx_inc;
                end
            end
            default: ;
        endcase
    end

    assign ev_valid  = ev_valid_q;
    assign ev_key    = ev_key_q;
    assign ev_press  = ev_press_q;
    assign key_state = key_state_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Scoreboard bench for key_scan_arbiter with a short debounce count.
// Expected events are queued when keys are driven and popped as the DUT emits them.
module tb_key_scan_arbiter;

    localparam int          N_KEYS = 4;
    localparam int          IDX_W  = 2;
    localparam int          CNT_W  = 30;
    localparam logic [29:0] T_DEB  = 30'd15;
    localparam int          LAT    = 19;

    typedef struct {
        logic [IDX_W-1:0] key;
        logic             press;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_KEYS-1:0] key_in = 4'hF;
    logic              ev_ready = 1'b1;
    logic              ev_valid;
    logic [IDX_W-1:0]  ev_key;
    logic              ev_press;
    logic [N_KEYS-1:0] key_state;
    logic              busy;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    key_scan_arbiter #(
        .N_KEYS (N_KEYS),
        .CNT_W  (CNT_W),
        .T_DEB  (T_DEB),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_key    (ev_key),
        .ev_press  (ev_press),
        .key_state (key_state),
        .busy      (busy)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ev_valid; reports whether it came and after how many edges
    task automatic wait_valid(input int max, output bit seen, output int n);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max) begin
            tick();
            n++;
            if (ev_valid) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_in = 4'hF;
        ev_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++; if (ev_valid !== 1'b0) $display("FAIL reset_ev_valid got %b want 0", ev_valid); else passed++;
        total++; if (key_state !== 4'b1111) $display("FAIL reset_key_state got %b want 1111", key_state); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (ev_key !== 2'd0 || ev_press !== 1'b0) $display("FAIL reset_ev_fields got key=%0d press=%b want 0/0", ev_key, ev_press); else passed++;
        $display("reset: ev_valid=%b key_state=%b busy=%b", ev_valid, key_state, busy);
    endtask

    task automatic test_clean_press();
        exp_t e;
        bit   seen;
        int   n;
        exp_q.push_back('{key: 2'd2, press: 1'b1});
        key_in[2] = 1'b0;
        wait_valid(40, seen, n);
        e = exp_q.pop_front();
        $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
        total++; if (!seen || n != LAT) $display("FAIL press_latency got seen=%0d cycles=%0d want 1/%0d", seen, n, LAT); else passed++;
        total++; if (ev_key !== e.key || ev_press !== e.press) $display("FAIL press_event got key=%0d press=%b want key=%0d press=%b", ev_key, ev_press, e.key, e.press); else passed++;
        total++; if (key_state !== 4'b1011) $display("FAIL press_key_state got %b want 1011", key_state); else passed++;
        tick();
        total++; if (ev_valid !== 1'b0) $display("FAIL press_single_cycle got ev_valid=%b want 0", ev_valid); else passed++;
        repeat (5) tick();
        exp_q.push_back('{key: 2'd2, press: 1'b0});
        key_in[2] = 1'b1;
        wait_valid(40, seen, n);
        e = exp_q.pop_front();
        $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
        total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL release_event got seen=%0d key=%0d press=%b want key=%0d press=%b", seen, ev_key, ev_press, e.key, e.press); else passed++;
        total++; if (key_state !== 4'b1111) $display("FAIL release_key_state got %b want 1111", key_state); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_bounce();
        bit any_valid = 1'b0;
        key_in[1] = 1'b0;
        repeat (5) begin
            tick();
            if (ev_valid) any_valid = 1'b1;
        end
        key_in[1] = 1'b1;
        repeat (25) begin
            tick();
            if (ev_valid) any_valid = 1'b1;
        end
        $display("bounce: any_valid=%b busy=%b key_state=%b", any_valid, busy, key_state);
        total++; if (any_valid !== 1'b0) $display("FAIL bounce_no_event got ev_valid seen=%b want 0", any_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL bounce_busy got %b want 0", busy); else passed++;
        total++; if (key_state !== 4'b1111) $display("FAIL bounce_key_state got %b want 1111", key_state); else passed++;
    endtask

    // After the bounce on key 1 the pointer sits at 2, so key 3 beats key 0
    task automatic test_ptr_after_bounce();
        exp_t e;
        bit   seen;
        int   n;
        exp_q.push_back('{key: 2'd3, press: 1'b1});
        exp_q.push_back('{key: 2'd0, press: 1'b1});
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_valid(60, seen, n);
            e = exp_q.pop_front();
            $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
            total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL ptr_order_%0d got seen=%0d key=%0d press=%b want key=%0d press=%b", k, seen, ev_key, ev_press, e.key, e.press); else passed++;
        end
        total++; if (key_state !== 4'b0110) $display("FAIL ptr_key_state got %b want 0110", key_state); else passed++;
        exp_q.push_back('{key: 2'd3, press: 1'b0});
        exp_q.push_back('{key: 2'd0, press: 1'b0});
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_valid(60, seen, n);
            e = exp_q.pop_front();
            $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
            total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL ptr_release_%0d got seen=%0d key=%0d press=%b want key=%0d press=%b", k, seen, ev_key, ev_press, e.key, e.press); else passed++;
        end
        repeat (3) tick();
    endtask

    task automatic test_simultaneous();
        exp_t e;
        bit   seen;
        int   n;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back('{key: 2'd0, press: 1'b1});
        exp_q.push_back('{key: 2'd3, press: 1'b1});
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_valid(60, seen, n);
            e = exp_q.pop_front();
            $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
            total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL simul_order_%0d got seen=%0d key=%0d press=%b want key=%0d press=%b", k, seen, ev_key, ev_press, e.key, e.press); else passed++;
        end
        total++; if (key_state !== 4'b0110) $display("FAIL simul_key_state got %b want 0110", key_state); else passed++;
        // ptr is 0 after serving key 3, so key 0 is released first
        exp_q.push_back('{key: 2'd0, press: 1'b0});
        exp_q.push_back('{key: 2'd3, press: 1'b0});
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_valid(60, seen, n);
            e = exp_q.pop_front();
            $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
            total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL simul_release_%0d got seen=%0d key=%0d press=%b want key=%0d press=%b", k, seen, ev_key, ev_press, e.key, e.press); else passed++;
        end
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   seen;
        bit   stable = 1'b1;
        int   n;
        ev_ready = 1'b0;
        exp_q.push_back('{key: 2'd1, press: 1'b1});
        key_in[1] = 1'b0;
        wait_valid(40, seen, n);
        e = exp_q.pop_front();
        $display("event: key=%0d press=%b after %0d cycles (held)", ev_key, ev_press, n);
        total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL bp_event got seen=%0d key=%0d press=%b want key=%0d press=%b", seen, ev_key, ev_press, e.key, e.press); else passed++;
        exp_q.push_back('{key: 2'd2, press: 1'b1});
        key_in[2] = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (ev_valid !== 1'b1 || ev_key !== e.key || ev_press !== e.press || busy !== 1'b1) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) $display("FAIL bp_hold got valid=%b key=%0d press=%b busy=%b want 1/%0d/%b/1", ev_valid, ev_key, ev_press, busy, e.key, e.press); else passed++;
        ev_ready = 1'b1;
        tick();
        total++; if (ev_valid !== 1'b0) $display("FAIL bp_handshake got ev_valid=%b want 0", ev_valid); else passed++;
        wait_valid(40, seen, n);
        e = exp_q.pop_front();
        $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
        total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL bp_pending got seen=%0d key=%0d press=%b want key=%0d press=%b", seen, ev_key, ev_press, e.key, e.press); else passed++;
        total++; if (key_state !== 4'b1001) $display("FAIL bp_key_state got %b want 1001", key_state); else passed++;
        // ptr is 3 after key 2, so key 1 wraps ahead of key 2
        exp_q.push_back('{key: 2'd1, press: 1'b0});
        exp_q.push_back('{key: 2'd2, press: 1'b0});
        key_in[1] = 1'b1;
        key_in[2] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_valid(60, seen, n);
            e = exp_q.pop_front();
            $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
            total++; if (!seen || ev_key !== e.key || ev_press !== e.press) $display("FAIL bp_release_%0d got seen=%0d key=%0d press=%b want key=%0d press=%b", k, seen, ev_key, ev_press, e.key, e.press); else passed++;
        end
        total++; if (key_state !== 4'b1111) $display("FAIL bp_final_state got %b want 1111", key_state); else passed++;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        bit   seen;
        bit   any_valid = 1'b0;
        int   n;
        key_in[3] = 1'b0;
        repeat (12) begin
            tick();
            if (ev_valid) any_valid = 1'b1;
        end
        total++; if (busy !== 1'b1) $display("FAIL midrst_counting got busy=%b want 1", busy); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset mid-count: busy=%b ev_valid=%b key_state=%b", busy, ev_valid, key_state);
        total++; if (busy !== 1'b0 || ev_valid !== 1'b0 || any_valid !== 1'b0) $display("FAIL midrst_dropped got busy=%b valid=%b earlier_valid=%b want 0/0/0", busy, ev_valid, any_valid); else passed++;
        total++; if (key_state !== 4'b1111) $display("FAIL midrst_key_state got %b want 1111", key_state); else passed++;
        exp_q.push_back('{key: 2'd3, press: 1'b1});
        wait_valid(40, seen, n);
        e = exp_q.pop_front();
        $display("event: key=%0d press=%b after %0d cycles", ev_key, ev_press, n);
        total++; if (!seen || n != LAT || ev_key !== e.key || ev_press !== e.press) $display("FAIL midrst_repress got seen=%0d cycles=%0d key=%0d press=%b want 1/%0d/%0d/%b", seen, n, ev_key, ev_press, LAT, e.key, e.press); else passed++;
        total++; if (key_state !== 4'b0111) $display("FAIL midrst_final_state got %b want 0111", key_state); else passed++;
        tick();
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ptr_after_bounce();
        test_simultaneous();
        test_backpressure();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
